// File: rtl/ram_burst_pkg.sv
// Shared constants, state encoding and response-entry type for the ram_burst_ctrl front-end.
package ram_burst_pkg;
  localparam int RAM_WIDTH  = 64;
  localparam int ADDR_SIZE  = 12;
  localparam int LEN_W      = 8;
  localparam int RESP_DEPTH = 4;
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int BEAT_W     = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                 last;
    logic [RAM_WIDTH-1:0] data;
  } resp_t;

  // True when the burst's final word would land past the top of the address space.
  function automatic logic burst_overflows(input logic [ADDR_SIZE-1:0] addr,
                                           input logic [LEN_W-1:0]     len);
    logic [ADDR_SIZE:0] w_end;
    w_end = {1'b0, addr} + {{(ADDR_SIZE + 1 - LEN_W){1'b0}}, len};
    return w_end[ADDR_SIZE];
  endfunction
endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-beat, read-response and ram_chip signals of ram_burst_ctrl.
// slave = controller side, master = host plus ram_chip side.
interface ram_burst_ctrl_if;
  import ram_burst_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [LEN_W-1:0]     cmd_len;
  logic                 cmd_err;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [RAM_WIDTH-1:0] wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [RAM_WIDTH-1:0] rd_data;
  logic                 rd_last;
  logic                 busy;
  logic                 ram_chip_en;
  logic                 ram_write;
  logic                 ram_read;
  logic [ADDR_SIZE-1:0] ram_wr_address;
  logic [ADDR_SIZE-1:0] ram_rd_address;
  logic [RAM_WIDTH-1:0] ram_data_in;
  logic [RAM_WIDTH-1:0] ram_data_out;
  logic                 ram_data_valid;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           ram_data_out, ram_data_valid,
    output cmd_ready, cmd_err, wr_ready, rd_valid, rd_data, rd_last, busy,
           ram_chip_en, ram_write, ram_read, ram_wr_address, ram_rd_address, ram_data_in
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           ram_data_out, ram_data_valid,
    input  cmd_ready, cmd_err, wr_ready, rd_valid, rd_data, rd_last, busy,
           ram_chip_en, ram_write, ram_read, ram_wr_address, ram_rd_address, ram_data_in
  );
endinterface

// File: rtl/ram_resp_fifo.sv
// First-word-fall-through response FIFO; push and pop may share a cycle, including when full.
module ram_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst front-end for ram_chip: streams write beats / read addresses and returns reads via a FIFO.
// Build macro RAM_BURST_WRAP_EN: bursts wrap past 0xFFF instead of being rejected with cmd_err.
module ram_burst_ctrl
  import ram_burst_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  ram_burst_ctrl_if.slave bus
);
  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [LEN_W-1:0]     r_len;
  logic [BEAT_W-1:0]    r_sent;
  logic [BEAT_W-1:0]    r_ret;
  logic [CNT_W-1:0]     r_outst;
  logic                 r_err;

  logic             w_cmd_ready;
  logic             w_wr_ready;
  logic             w_cmd_fire;
  logic             w_wr_fire;
  logic             w_issue;
  logic             w_ret;
  logic             w_oob;
  logic             w_room;
  logic             w_last_sent;
  logic             w_last_ret;
  logic             w_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W:0]   w_inflight;
  resp_t            w_push_entry;
  resp_t            w_head;

`ifdef RAM_BURST_WRAP_EN
  assign w_oob = 1'b0;
`else
  assign w_oob = burst_overflows(bus.cmd_addr, bus.cmd_len);
`endif

  // Reads in flight plus queued responses never exceed the FIFO depth, so pushes cannot overflow.
  assign w_inflight   = {1'b0, r_outst} + {1'b0, w_fifo_count};
  assign w_room       = (w_inflight < (CNT_W + 1)'(RESP_DEPTH));
  assign w_last_sent  = (r_sent == {1'b0, r_len});
  assign w_last_ret   = (r_ret == {1'b0, r_len});
  assign w_ret        = bus.ram_data_valid && (r_outst != '0) &&
                        ((r_state == READ) || (r_state == DRAIN));
  assign w_push_entry = {w_last_ret, bus.ram_data_out};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_wr_ready   = 1'b0;
    w_cmd_fire   = 1'b0;
    w_wr_fire    = 1'b0;
    w_issue      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        w_cmd_fire  = bus.cmd_valid;
        if (bus.cmd_valid && !w_oob) w_state_next = bus.cmd_write ? WRITE : READ;
      end
      WRITE: begin
        w_wr_ready = 1'b1;
        w_wr_fire  = bus.wr_valid;
        if (bus.wr_valid && w_last_sent) w_state_next = IDLE;
      end
      READ: begin
        w_issue = w_room;
        if (w_room && w_last_sent) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_ret && w_last_ret) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A rejected command still loads the fields; it is harmless because the FSM stays in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_sent  <= '0;
      r_ret   <= '0;
      r_outst <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_cmd_fire && w_oob;
      if (w_cmd_fire) begin
        r_addr <= bus.cmd_addr;
        r_len  <= bus.cmd_len;
        r_sent <= '0;
        r_ret  <= '0;
      end else begin
        if (w_wr_fire || w_issue) begin
          r_addr <= r_addr + 1'b1;
          r_sent <= r_sent + 1'b1;
        end
        if (w_ret) r_ret <= r_ret + 1'b1;
      end
      case ({w_issue, w_ret})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: ;
      endcase
    end
  end

  ram_resp_fifo #(
    .DEPTH(RESP_DEPTH),
    .WIDTH($bits(resp_t))
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ret),
    .i_data  (w_push_entry),
    .i_pop   (bus.rd_ready),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign bus.cmd_ready      = w_cmd_ready;
  assign bus.cmd_err        = r_err;
  assign bus.wr_ready       = w_wr_ready;
  assign bus.busy           = (r_state != IDLE);
  assign bus.ram_chip_en    = w_wr_fire || w_issue;
  assign bus.ram_write      = w_wr_fire;
  assign bus.ram_read       = w_issue;
  assign bus.ram_wr_address = w_wr_fire ? r_addr : '0;
  assign bus.ram_rd_address = w_issue ? r_addr : '0;
  assign bus.ram_data_in    = w_wr_fire ? bus.wr_data : '0;
  assign bus.rd_valid       = !w_empty;
  assign bus.rd_data        = w_empty ? '0 : w_head.data;
  assign bus.rd_last        = !w_empty && w_head.last;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a ram_chip model returning read data one cycle after ram_read.
// The 0xFFE burst expectations depend on RAM_BURST_WRAP_EN.
module tb_ram_burst_ctrl;
  import ram_burst_pkg::*;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wrRec_t;

  localparam logic [63:0] SEED_A = 64'hA0A0_0000_0000_00A0;
  localparam logic [63:0] SEED_B = 64'hB0B0_0000_0000_00B0;
  localparam logic [63:0] SEED_C = 64'hC0C0_0000_0000_00C0;
  localparam logic [63:0] SEED_D = 64'hD0D0_0000_0000_00D0;
  localparam logic [63:0] SEED_E = 64'h1111_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  wrRec_t      wrLog[$];
  logic [64:0] rdLog[$];
  int          ramReadCount = 0;
  logic [63:0] ramMem [4096];
  int          testCount = 0;
  int          failCount = 0;
  logic [11:0] wrapAddr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

  always #5 clk = ~clk;

  ram_burst_ctrl_if bus ();

  ram_burst_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ram_chip model plus monitors for RAM writes, RAM reads and consumed read beats.
  always @(posedge clk) begin
    if (bus.ram_chip_en === 1'b1 && bus.ram_write === 1'b1) begin
      ramMem[bus.ram_wr_address] <= bus.ram_data_in;
      wrLog.push_back('{addr: bus.ram_wr_address, data: bus.ram_data_in});
    end
    if (bus.ram_chip_en === 1'b1 && bus.ram_read === 1'b1) ramReadCount <= ramReadCount + 1;
    bus.ram_data_valid <= (bus.ram_chip_en === 1'b1) && (bus.ram_read === 1'b1);
    bus.ram_data_out   <= ramMem[bus.ram_rd_address];
    if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) rdLog.push_back({bus.rd_last, bus.rd_data});
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic write, input logic [11:0] addr, input logic [7:0] len);
    int waited;
    waited        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cmd_accept", 65'(waited < 100), 65'(1'b1));
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic writeBurst(input int beats, input logic [63:0] seed, input bit gap);
    int idx;
    int cycles;
    bit acc;
    idx    = 0;
    cycles = 0;
    while (idx < beats && cycles < 1000) begin
      bus.wr_valid = !(gap && (cycles % 2 == 1));
      bus.wr_data  = seed + 64'(idx);
      @(negedge clk);
      checkOutput("ram_write_strobe", 65'(bus.ram_write), 65'(bus.wr_valid));
      acc = bus.wr_valid && (bus.wr_ready === 1'b1);
      tick();
      if (acc) idx++;
      cycles++;
    end
    bus.wr_valid = 1'b0;
    checkOutput("wr_beats_done", 65'(idx), 65'(beats));
  endtask

  task automatic waitRdBeats(input int target);
    int cycles;
    cycles = 0;
    while (rdLog.size() < target && cycles < 500) begin
      tick();
      cycles++;
    end
    checkOutput("rd_beats_arrived", 65'(rdLog.size()), 65'(target));
  endtask

  initial begin
    int base;
    int rdBase;
    int rcBase;
    logic [64:0] expBeat;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 65'(bus.cmd_ready), 65'(1'b1));
    checkOutput("rst_busy", 65'(bus.busy), 65'(1'b0));
    checkOutput("rst_rd_valid", 65'(bus.rd_valid), 65'(1'b0));
    checkOutput("rst_cmd_err", 65'(bus.cmd_err), 65'(1'b0));
    checkOutput("rst_ram_chip_en", 65'(bus.ram_chip_en), 65'(1'b0));
    checkOutput("rst_wr_ready", 65'(bus.wr_ready), 65'(1'b0));
    checkOutput("rst_rd_data", 65'(bus.rd_data), 65'(64'h0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] write 0x010 len 3 back-to-back");
    base = wrLog.size();
    applyStimulus(1'b1, 12'h010, 8'd3);
    writeBurst(4, SEED_A, 1'b0);
    @(negedge clk);
    checkOutput("wr1_idle_after", 65'(bus.busy), 65'(1'b0));
    checkOutput("wr1_count", 65'(wrLog.size() - base), 65'(4));
    for (int i = 0; i < 4; i++) begin
      checkOutput("wr1_addr", 65'(wrLog[base + i].addr), 65'(12'h010 + 12'(i)));
      checkOutput("wr1_data", 65'(wrLog[base + i].data), 65'(SEED_A + 64'(i)));
    end
    tick();

    $display("[TB] read 0x010 len 3, rd_ready held high");
    bus.rd_ready = 1'b1;
    rdBase = rdLog.size();
    applyStimulus(1'b0, 12'h010, 8'd3);
    waitRdBeats(rdBase + 4);
    for (int i = 0; i < 4; i++) begin
      expBeat = {(i == 3), SEED_A + 64'(i)};
      checkOutput("rd1_beat", rdLog[rdBase + i], expBeat);
    end
    @(negedge clk);
    checkOutput("rd1_idle_after", 65'(bus.busy), 65'(1'b0));
    tick();

    $display("[TB] write 0x100 len 15");
    base = wrLog.size();
    applyStimulus(1'b1, 12'h100, 8'd15);
    writeBurst(16, SEED_E, 1'b0);
    checkOutput("wr16_count", 65'(wrLog.size() - base), 65'(16));
    checkOutput("wr16_last_addr", 65'(wrLog[base + 15].addr), 65'(12'h10F));

    $display("[TB] read 0x100 len 15 with rd_ready low");
    bus.rd_ready = 1'b0;
    rcBase = ramReadCount;
    rdBase = rdLog.size();
    applyStimulus(1'b0, 12'h100, 8'd15);
    repeat (20) tick();
    @(negedge clk);
    checkOutput("stall_reads_issued", 65'(ramReadCount - rcBase), 65'(4));
    checkOutput("stall_rd_valid", 65'(bus.rd_valid), 65'(1'b1));
    checkOutput("stall_busy", 65'(bus.busy), 65'(1'b1));
    checkOutput("stall_head_data", 65'(bus.rd_data), 65'(SEED_E));
    checkOutput("stall_head_last", 65'(bus.rd_last), 65'(1'b0));
    tick();
    bus.rd_ready = 1'b1;
    waitRdBeats(rdBase + 16);
    for (int i = 0; i < 16; i++) begin
      expBeat = {(i == 15), SEED_E + 64'(i)};
      checkOutput("rd16_beat", rdLog[rdBase + i], expBeat);
    end
    @(negedge clk);
    checkOutput("rd16_reads_total", 65'(ramReadCount - rcBase), 65'(16));
    checkOutput("rd16_idle_after", 65'(bus.busy), 65'(1'b0));
    tick();

    $display("[TB] write 0xFFC len 3 ends exactly at the top");
    base = wrLog.size();
    applyStimulus(1'b1, 12'hFFC, 8'd3);
    @(negedge clk);
    checkOutput("top_cmd_err", 65'(bus.cmd_err), 65'(1'b0));
    checkOutput("top_busy", 65'(bus.busy), 65'(1'b1));
    tick();
    writeBurst(4, SEED_D, 1'b0);
    checkOutput("top_count", 65'(wrLog.size() - base), 65'(4));
    for (int i = 0; i < 4; i++)
      checkOutput("top_addr", 65'(wrLog[base + i].addr), 65'(12'hFFC + 12'(i)));

    $display("[TB] write 0xFFE len 3 crosses the top");
    base = wrLog.size();
`ifdef RAM_BURST_WRAP_EN
    applyStimulus(1'b1, 12'hFFE, 8'd3);
    @(negedge clk);
    checkOutput("wrap_cmd_err", 65'(bus.cmd_err), 65'(1'b0));
    tick();
    writeBurst(4, SEED_C, 1'b0);
    checkOutput("wrap_count", 65'(wrLog.size() - base), 65'(4));
    for (int i = 0; i < 4; i++)
      checkOutput("wrap_addr", 65'(wrLog[base + i].addr), 65'(wrapAddr[i]));
`else
    applyStimulus(1'b1, 12'hFFE, 8'd3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = SEED_C;
    @(negedge clk);
    checkOutput("oob_cmd_err_pulse", 65'(bus.cmd_err), 65'(1'b1));
    checkOutput("oob_busy", 65'(bus.busy), 65'(1'b0));
    checkOutput("oob_wr_ready", 65'(bus.wr_ready), 65'(1'b0));
    checkOutput("oob_ram_write", 65'(bus.ram_write), 65'(1'b0));
    tick();
    @(negedge clk);
    checkOutput("oob_cmd_err_end", 65'(bus.cmd_err), 65'(1'b0));
    checkOutput("oob_cmd_ready", 65'(bus.cmd_ready), 65'(1'b1));
    tick();
    bus.wr_valid = 1'b0;
    checkOutput("oob_no_writes", 65'(wrLog.size() - base), 65'(0));
    checkOutput("oob_wrap_table_unused", 65'(wrapAddr[0]), 65'(12'hFFE));
`endif

    $display("[TB] write 0x020 len 3 with wr_valid gaps");
    base = wrLog.size();
    applyStimulus(1'b1, 12'h020, 8'd3);
    writeBurst(4, SEED_B, 1'b1);
    checkOutput("gap_count", 65'(wrLog.size() - base), 65'(4));
    for (int i = 0; i < 4; i++) begin
      checkOutput("gap_addr", 65'(wrLog[base + i].addr), 65'(12'h020 + 12'(i)));
      checkOutput("gap_data", 65'(wrLog[base + i].data), 65'(SEED_B + 64'(i)));
    end

    $display("[TB] reset during read 0x100 len 7");
    bus.rd_ready = 1'b0;
    applyStimulus(1'b0, 12'h100, 8'd7);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", 65'(bus.busy), 65'(1'b0));
    checkOutput("mid_rst_rd_valid", 65'(bus.rd_valid), 65'(1'b0));
    checkOutput("mid_rst_cmd_ready", 65'(bus.cmd_ready), 65'(1'b1));
    tick();
    bus.rd_ready = 1'b1;
    rdBase = rdLog.size();
    repeat (3) tick();
    @(negedge clk);
    checkOutput("late_data_dropped", 65'(bus.rd_valid), 65'(1'b0));
    checkOutput("late_no_beats", 65'(rdLog.size() - rdBase), 65'(0));
    tick();

    $display("[TB] single-beat read 0x010 after reset");
    rdBase = rdLog.size();
    applyStimulus(1'b0, 12'h010, 8'd0);
    waitRdBeats(rdBase + 1);
    checkOutput("single_beat", rdLog[rdBase], {1'b1, SEED_A});
    @(negedge clk);
    checkOutput("single_idle_after", 65'(bus.busy), 65'(1'b0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
